// File: rtl/spi_responder_if.sv
// rtl/spi_responder_if.sv - SPI pins plus local TX/RX byte and CRC handshake bundle for spi_responder
interface spi_responder_if;
   logic        _cs;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic        miso_oe;
   logic        selected;
   logic [7:0]  tx_data;
   logic        tx_load;
   logic        tx_empty;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ack;
   logic        rx_overrun;
   logic        crc_clear;
   logic        crc_source;
   logic [15:0] crc_out;

   modport slave (
      input  _cs, sclk, mosi, tx_data, tx_load, rx_ack, crc_clear, crc_source,
      output miso, miso_oe, selected, tx_empty, rx_data, rx_valid, rx_overrun, crc_out
   );

   modport master (
      output _cs, sclk, mosi, tx_data, tx_load, rx_ack, crc_clear, crc_source,
      input  miso, miso_oe, selected, tx_empty, rx_data, rx_valid, rx_overrun, crc_out
   );
endinterface

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - oversampled SPI mode-0 target with single-entry TX/RX byte buffers
// Optional SD data CRC16 accumulator enabled by defining SPI_RESPONDER_CRC_EN.
module spi_responder #(
   parameter logic [7:0] IDLE_FILL = 8'hFF
) (
   input logic            clk,
   input logic            rst,
   spi_responder_if.slave s
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t      state;
   state_t      state_nxt;

   logic        cs_s1, cs_s2, cs_s3;
   logic        sclk_s1, sclk_s2, sclk_s3;
   logic        mosi_s1, mosi_s2;
   logic        cs_fall, sclk_rise, sclk_fall;

   logic [7:0]  tx_sr;
   logic [7:0]  tx_buf;
   logic        tx_full;
   logic [7:0]  rx_sr;
   logic [7:0]  rx_nxt;
   logic [2:0]  bit_cnt;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_overrun;

   logic        load_evt;
   logic        shift_evt;
   logic        rx_evt;
   logic        byte_done;

   // mosi shares the sclk stage so the sampled bit lines up with the detected edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_s3   <= 1'b1;
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         cs_s1   <= s._cs;
         cs_s2   <= cs_s1;
         cs_s3   <= cs_s2;
         sclk_s1 <= s.sclk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         mosi_s1 <= s.mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   assign cs_fall   = cs_s3 & ~cs_s2;
   assign sclk_rise = ~sclk_s3 & sclk_s2;
   assign sclk_fall = sclk_s3 & ~sclk_s2;
   assign rx_nxt    = {rx_sr[6:0], mosi_s2};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_evt  = 1'b0;
      shift_evt = 1'b0;
      rx_evt    = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_nxt = ACTIVE;
               load_evt  = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_s2) begin
               state_nxt = IDLE;
            end else begin
               rx_evt = sclk_rise;
               if (sclk_fall) begin
                  if (bit_cnt == 3'd0) load_evt  = 1'b1;
                  else                 shift_evt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign byte_done = rx_evt && (bit_cnt == 3'd7);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_sr      <= 8'h00;
         tx_buf     <= 8'h00;
         tx_full    <= 1'b0;
         rx_sr      <= 8'h00;
         bit_cnt    <= 3'd0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         if (load_evt)       tx_sr <= tx_full ? tx_buf : IDLE_FILL;
         else if (shift_evt) tx_sr <= {tx_sr[6:0], 1'b0};

         // a load racing an empty-buffer boundary lands in the buffer, the shifter gets fill
         if (s.tx_load && !tx_full) begin
            tx_buf  <= s.tx_data;
            tx_full <= 1'b1;
         end else if (load_evt) begin
            tx_full <= 1'b0;
         end

         if (state_nxt == IDLE) begin
            bit_cnt <= 3'd0;
            rx_sr   <= 8'h00;
         end else if (rx_evt) begin
            rx_sr   <= rx_nxt;
            bit_cnt <= bit_cnt + 3'd1;
         end

         if (byte_done) begin
            rx_data    <= rx_nxt;
            rx_valid   <= 1'b1;
            rx_overrun <= s.rx_ack ? 1'b0 : (rx_overrun | rx_valid);
         end else if (s.rx_ack) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
         end
      end
   end

   assign s.miso       = (state == ACTIVE) ? tx_sr[7] : 1'b1;
   assign s.miso_oe    = (state == ACTIVE);
   assign s.selected   = (state == ACTIVE);
   assign s.tx_empty   = ~tx_full;
   assign s.rx_data    = rx_data;
   assign s.rx_valid   = rx_valid;
   assign s.rx_overrun = rx_overrun;

`ifdef SPI_RESPONDER_CRC_EN
   logic [15:0] crc;
   logic        crc_bit;
   logic        crc_fb;

   assign crc_bit = s.crc_source ? tx_sr[7] : mosi_s2;
   assign crc_fb  = crc[15] ^ crc_bit;

   // CRC16-CCITT, MSB first, zero init, one bit per sampled sclk rise
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              crc <= 16'h0000;
      else if (s.crc_clear) crc <= 16'h0000;
      else if (rx_evt)      crc <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
   end

   assign s.crc_out = crc;
`else
   logic unused_crc;
   assign unused_crc = s.crc_clear ^ s.crc_source;
   assign s.crc_out  = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - directed self-checking bench for spi_responder
// Expects crc_out = 16'h7FA1 after 512 x 8'hFF when SPI_RESPONDER_CRC_EN is defined, else 0.
module tb_spi_responder;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   spi_responder_if sif ();

   spi_responder #(.IDLE_FILL(8'hFF)) dut (
      .clk (clk),
      .rst (rst),
      .s   (sif)
   );

`ifdef SPI_RESPONDER_CRC_EN
   localparam logic [15:0] CRC_EXP = 16'h7FA1;
`else
   localparam logic [15:0] CRC_EXP = 16'h0000;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_tx(input logic [7:0] d);
      sif.tx_data = d;
      sif.tx_load = 1'b1;
      @(negedge clk);
      sif.tx_load = 1'b0;
   endtask

   task automatic ack_rx();
      sif.rx_ack = 1'b1;
      @(negedge clk);
      sif.rx_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic cs_set(input logic v);
      sif._cs = v;
      wait_clks(4);
   endtask

   // master side, mode 0: miso sampled at the rising sclk, half periods of 4 clk
   task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         sif.mosi = mo[7-i];
         wait_clks(4);
         mi[7-i] = sif.miso;
         sif.sclk = 1'b1;
         wait_clks(4);
         sif.sclk = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] mi;
      total = 0;
      bad   = 0;
      rst            = 1'b1;
      sif._cs        = 1'b1;
      sif.sclk       = 1'b0;
      sif.mosi       = 1'b0;
      sif.tx_data    = 8'h00;
      sif.tx_load    = 1'b0;
      sif.rx_ack     = 1'b0;
      sif.crc_clear  = 1'b0;
      sif.crc_source = 1'b0;
      wait_clks(3);
      rst = 1'b0;
      wait_clks(3);

      chk("rst_miso", {15'd0, sif.miso}, 16'd1);
      chk("rst_oe", {15'd0, sif.miso_oe}, 16'd0);
      chk("rst_sel", {15'd0, sif.selected}, 16'd0);
      chk("rst_tx_empty", {15'd0, sif.tx_empty}, 16'd1);
      chk("rst_rx_valid", {15'd0, sif.rx_valid}, 16'd0);
      chk("rst_rx_data", {8'd0, sif.rx_data}, 16'h0000);
      chk("rst_overrun", {15'd0, sif.rx_overrun}, 16'd0);
      chk("rst_crc", sif.crc_out, 16'h0000);

      // single byte: A5 out, 3C in
      load_tx(8'hA5);
      chk("load_tx_empty", {15'd0, sif.tx_empty}, 16'd0);
      cs_set(1'b0);
      chk("sel_active", {15'd0, sif.selected}, 16'd1);
      chk("sel_oe", {15'd0, sif.miso_oe}, 16'd1);
      chk("sel_consumed", {15'd0, sif.tx_empty}, 16'd1);
      xfer(8'h3C, 8, mi);
      wait_clks(4);
      chk("b1_miso", {8'd0, mi}, 16'h00A5);
      chk("b1_rx_data", {8'd0, sif.rx_data}, 16'h003C);
      chk("b1_rx_valid", {15'd0, sif.rx_valid}, 16'd1);
      chk("b1_tx_empty", {15'd0, sif.tx_empty}, 16'd1);
      ack_rx();
      chk("b1_ack", {15'd0, sif.rx_valid}, 16'd0);

      // two bytes, nothing loaded, no ack in between
      xfer(8'h5A, 8, mi);
      chk("b2_fill", {8'd0, mi}, 16'h00FF);
      xfer(8'hC3, 8, mi);
      wait_clks(4);
      chk("b3_fill", {8'd0, mi}, 16'h00FF);
      chk("b3_rx_data", {8'd0, sif.rx_data}, 16'h00C3);
      chk("b3_overrun", {15'd0, sif.rx_overrun}, 16'd1);
      chk("b3_valid", {15'd0, sif.rx_valid}, 16'd1);
      ack_rx();
      chk("b3_ack_valid", {15'd0, sif.rx_valid}, 16'd0);
      chk("b3_ack_overrun", {15'd0, sif.rx_overrun}, 16'd0);
      cs_set(1'b1);
      chk("idle_oe", {15'd0, sif.miso_oe}, 16'd0);
      chk("idle_miso", {15'd0, sif.miso}, 16'd1);

      // aborted byte after 5 bits; buffered byte survives into the next transfer
      load_tx(8'h81);
      cs_set(1'b0);
      load_tx(8'h42);
      load_tx(8'h99);
      xfer(8'hF0, 5, mi);
      chk("abort_bits", {8'd0, mi}, 16'h0080);
      cs_set(1'b1);
      chk("abort_valid", {15'd0, sif.rx_valid}, 16'd0);
      chk("abort_oe", {15'd0, sif.miso_oe}, 16'd0);
      chk("abort_buf_kept", {15'd0, sif.tx_empty}, 16'd0);
      cs_set(1'b0);
      xfer(8'h11, 8, mi);
      wait_clks(4);
      chk("resume_miso", {8'd0, mi}, 16'h0042);
      chk("resume_rx", {8'd0, sif.rx_data}, 16'h0011);
      chk("resume_valid", {15'd0, sif.rx_valid}, 16'd1);
      ack_rx();
      cs_set(1'b1);

      // CRC over 512 bytes of FF on MOSI
      sif.crc_clear = 1'b1;
      @(negedge clk);
      sif.crc_clear = 1'b0;
      chk("crc_cleared", sif.crc_out, 16'h0000);
      cs_set(1'b0);
      for (int b = 0; b < 512; b++) xfer(8'hFF, 8, mi);
      wait_clks(4);
      chk("crc_512_ff", sif.crc_out, CRC_EXP);
      chk("crc_rx_data", {8'd0, sif.rx_data}, 16'h00FF);
      ack_rx();
      cs_set(1'b1);

      // reset mid-byte, then a clean transfer
      load_tx(8'h3C);
      cs_set(1'b0);
      xfer(8'hAA, 3, mi);
      rst = 1'b1;
      #1;
      chk("mrst_miso", {15'd0, sif.miso}, 16'd1);
      chk("mrst_oe", {15'd0, sif.miso_oe}, 16'd0);
      chk("mrst_sel", {15'd0, sif.selected}, 16'd0);
      chk("mrst_tx_empty", {15'd0, sif.tx_empty}, 16'd1);
      chk("mrst_rx_valid", {15'd0, sif.rx_valid}, 16'd0);
      chk("mrst_crc", sif.crc_out, 16'h0000);
      sif._cs = 1'b1;
      wait_clks(4);
      rst = 1'b0;
      wait_clks(2);
      load_tx(8'hE7);
      cs_set(1'b0);
      xfer(8'h5A, 8, mi);
      wait_clks(4);
      chk("post_rst_miso", {8'd0, mi}, 16'h00E7);
      chk("post_rst_rx", {8'd0, sif.rx_data}, 16'h005A);
      chk("post_rst_valid", {15'd0, sif.rx_valid}, 16'd1);
      chk("post_rst_overrun", {15'd0, sif.rx_overrun}, 16'd0);
      cs_set(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
